// File: rtl/display_scan.sv
// Time-multiplexed driver for a four-digit seven-segment display fed through
// an external hex-to-segment decoder, with anti-ghost guard and leading-zero blanking.
module display_scan #(
  parameter int DIV_W = 17,
  parameter int GUARD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  les,
  input  logic        lzb_en,
  output logic [3:0]  hex,
  output logic        LE,
  output logic        point,
  output logic [3:0]  AN,
  output logic        frame
);

  localparam logic [DIV_W-1:0] GUARD_CNT = DIV_W'(GUARD);
  localparam logic [DIV_W-1:0] CNT_MAX   = '1;

  logic [DIV_W-1:0] cnt;
  logic [1:0]       sel;
  logic [15:0]      sh_hex;
  logic [3:0]       sh_pt;
  logic [3:0]       sh_le;
  logic [3:0]       lz;
  logic [3:0]       digit_hex;

  // A digit is a leading zero when it and every more significant digit are zero;
  // digit 0 is always shown so an all-zero value still displays "0".
  always_comb begin
    lz        = 4'b0000;
    lz[1]     = lzb_en & (sh_hex[15:4] == 12'h000);
    lz[2]     = lzb_en & (sh_hex[15:8] == 8'h00);
    lz[3]     = lzb_en & (sh_hex[15:12] == 4'h0);
    digit_hex = sh_hex[4*sel +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      sel    <= 2'd0;
      sh_hex <= 16'h0000;
      sh_pt  <= 4'h0;
      sh_le  <= 4'hF;
      hex    <= 4'h0;
      LE     <= 1'b1;
      point  <= 1'b0;
      AN     <= 4'hF;
      frame  <= 1'b0;
    end else begin
      cnt <= cnt + DIV_W'(1);
      if (cnt == CNT_MAX)
        sel <= sel + 2'd1;

      // Capturing mid-slot leaves the scan position alone.
      if (load) begin
        sh_hex <= hexs;
        sh_pt  <= points;
        sh_le  <= les;
      end

      hex   <= digit_hex;
      point <= sh_pt[sel];
      LE    <= sh_le[sel] | lz[sel];
      AN    <= (cnt < GUARD_CNT) ? 4'hF : ~(4'b0001 << sel);
      frame <= (sel == 2'd0) && (cnt == '0);
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Randomised and directed bench for display_scan (DIV_W=3, GUARD=2) checked
// every cycle against a slot-arithmetic model, plus literal frame snapshots.
module tb_display_scan;

  localparam int DIV_W = 3;
  localparam int GUARD = 2;
  localparam int SLOT  = 8;
  localparam int FRAME = 32;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic        lzb_en;
  logic [3:0]  hex;
  logic        LE;
  logic        point;
  logic [3:0]  AN;
  logic        frame;

  display_scan #(.DIV_W(DIV_W), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .load(load), .hexs(hexs), .points(points),
    .les(les), .lzb_en(lzb_en), .hex(hex), .LE(LE), .point(point),
    .AN(AN), .frame(frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  logic check_en;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: position in the scan follows from the number of edges since reset.
  int          m_edges;
  logic [15:0] m_hex;
  logic [3:0]  m_pt;
  logic [3:0]  m_le;
  int          m_pos;
  int          m_digit;
  logic [15:0] m_tail;
  logic [3:0]  exp_hex;
  logic        exp_le;
  logic        exp_pt;
  logic [3:0]  exp_an;
  logic        exp_frame;

  always_comb begin
    m_pos   = m_edges % SLOT;
    m_digit = (m_edges / SLOT) % 4;
    m_tail  = m_hex >> (4 * m_digit);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges   <= 0;
      m_hex     <= 16'h0000;
      m_pt      <= 4'h0;
      m_le      <= 4'hF;
      exp_hex   <= 4'h0;
      exp_le    <= 1'b1;
      exp_pt    <= 1'b0;
      exp_an    <= 4'hF;
      exp_frame <= 1'b0;
    end else begin
      exp_hex   <= m_tail[3:0];
      exp_le    <= m_le[m_digit] | (lzb_en && m_digit > 0 && m_tail == 16'h0000);
      exp_pt    <= m_pt[m_digit];
      exp_an    <= (m_pos < GUARD) ? 4'hF : (4'hF ^ (4'h1 << m_digit));
      exp_frame <= (m_edges % FRAME) == 0;
      m_edges   <= m_edges + 1;
      if (load) begin
        m_hex <= hexs;
        m_pt  <= points;
        m_le  <= les;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_output("cyc_hex", hex, exp_hex);
      check_output("cyc_le", LE, exp_le);
      check_output("cyc_point", point, exp_pt);
      check_output("cyc_an", AN, exp_an);
      check_output("cyc_frame", frame, exp_frame);
    end
  end

  logic [3:0] an_s [FRAME];
  logic [3:0] hex_s[FRAME];
  logic       le_s [FRAME];
  logic       pt_s [FRAME];

  task automatic apply_stimulus(input logic [15:0] h, input logic [3:0] p,
                                input logic [3:0] l, input logic z);
    hexs   = h;
    points = p;
    les    = l;
    lzb_en = z;
    load   = 1'b1;
    @(posedge clk) #1;
    load   = 1'b0;
  endtask

  task automatic wait_frame(output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk) #1;
      if (frame === 1'b1) found = 1;
    end
    if (!found) check_output("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture_frame();
    bit found;
    wait_frame(found);
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(posedge clk) #1;
      an_s[j]  = AN;
      hex_s[j] = hex;
      le_s[j]  = LE;
      pt_s[j]  = point;
    end
  endtask

  initial begin
    int  pulses, first, off_slot, not_blank;
    bit  found;
    rst = 1'b0; load = 1'b0; hexs = 16'h0; points = 4'h0; les = 4'h0;
    lzb_en = 1'b0; check_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_en = 1'b1;
    check_output("rst_an", AN, 4'hF);
    check_output("rst_le", LE, 1'b1);
    check_output("rst_hex", hex, 4'h0);
    @(posedge clk) #1 rst = 1'b0;

    pulses = 0; first = -1; off_slot = 0; not_blank = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk) #1;
      if (frame === 1'b1) begin
        if (first < 0) first = k;
        pulses++;
        if (k % FRAME != 0) off_slot++;
      end
      if (LE !== 1'b1) not_blank++;
    end
    check_output("frame_count", pulses, 4);
    check_output("frame_first", first, 0);
    check_output("frame_offslot", off_slot, 0);
    check_output("blank_until_load", not_blank, 0);

    apply_stimulus(16'h1234, 4'b0100, 4'b0000, 1'b0);
    capture_frame();
    check_output("scan_guard0", an_s[0], 4'hF);
    check_output("scan_guard1", an_s[1], 4'hF);
    check_output("scan_an0", an_s[4], 4'b1110);
    check_output("scan_hex0", hex_s[4], 4'h4);
    check_output("scan_an1", an_s[12], 4'b1101);
    check_output("scan_hex1", hex_s[12], 4'h3);
    check_output("scan_an2", an_s[20], 4'b1011);
    check_output("scan_hex2", hex_s[20], 4'h2);
    check_output("scan_pt2", pt_s[20], 1'b1);
    check_output("scan_pt0", pt_s[4], 1'b0);
    check_output("scan_an3", an_s[28], 4'b0111);
    check_output("scan_hex3", hex_s[28], 4'h1);

    apply_stimulus(16'h0050, 4'b0000, 4'b0000, 1'b1);
    capture_frame();
    check_output("lzb_le0", le_s[4], 1'b0);
    check_output("lzb_hex0", hex_s[4], 4'h0);
    check_output("lzb_le1", le_s[12], 1'b0);
    check_output("lzb_hex1", hex_s[12], 4'h5);
    check_output("lzb_le2", le_s[20], 1'b1);
    check_output("lzb_le3", le_s[28], 1'b1);

    apply_stimulus(16'h0000, 4'b0000, 4'b0000, 1'b1);
    capture_frame();
    check_output("zero_le", {le_s[28], le_s[20], le_s[12], le_s[4]}, 4'b1110);
    lzb_en = 1'b0;
    capture_frame();
    check_output("nolzb_le", {le_s[28], le_s[20], le_s[12], le_s[4]}, 4'b0000);

    apply_stimulus(16'h1234, 4'b0000, 4'b0000, 1'b0);
    wait_frame(found);
    repeat (20) @(posedge clk) #1;
    hexs = 16'hABCD; load = 1'b1;
    @(posedge clk) #1;
    load = 1'b0;
    check_output("mid_old_hex", hex, 4'h2);
    @(posedge clk) #1;
    check_output("mid_new_hex", hex, 4'hB);
    check_output("mid_an", AN, 4'b1011);
    @(posedge clk) #1;
    check_output("mid_slot_last", AN, 4'b1011);
    @(posedge clk) #1;
    check_output("mid_slot_end", AN, 4'hF);
    check_output("mid_next_hex", hex, 4'hA);
    repeat (8) @(posedge clk) #1;
    check_output("mid_frame", frame, 1'b1);

    @(posedge clk) #3;
    rst = 1'b1; load = 1'b1; hexs = 16'hFFFF; les = 4'h0; points = 4'hF;
    #1;
    check_output("async_an", AN, 4'hF);
    check_output("async_le", LE, 1'b1);
    check_output("async_hex", hex, 4'h0);
    check_output("async_point", point, 1'b0);
    check_output("async_frame", frame, 1'b0);
    @(posedge clk) #1;
    rst = 1'b0; load = 1'b0;
    capture_frame();
    check_output("rstload_le", {le_s[28], le_s[20], le_s[12], le_s[4]}, 4'b1111);
    check_output("rstload_hex", hex_s[20], 4'h0);

    for (int c = 0; c < 400; c++) begin
      hexs   = 16'($urandom) & {{4{1'($urandom_range(0, 1))}}, {4{1'($urandom_range(0, 1))}},
                                {4{1'($urandom_range(0, 1))}}, 4'hF};
      points = 4'($urandom);
      les    = 4'($urandom);
      if ($urandom_range(0, 7) == 0) lzb_en = ~lzb_en;
      load   = ($urandom_range(0, 9) == 0);
      rst    = ($urandom_range(0, 149) == 0);
      @(posedge clk) #1;
    end
    rst = 1'b0; load = 1'b0;
    @(posedge clk) #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
